seq_det_sched: RTL and testbench
================================

Name: seq_det_sched

Overview:
Time-shared, programmable, overlapping serial pattern detector. It serves NCH independent bit-serial channels. A round-robin scheduler grants one channel per cycle to a single compare engine. Per-channel history and fill context are held in registers, so each channel behaves as if it had its own detector. It sits between the serial front-ends and the event/interrupt logic, and replaces per-channel hard-coded detector FSMs.

Parameters:
NCH, 4, number of requesting channels (2..16)
CH_W, 2, channel index width; must equal clog2(NCH)
PAT_W, 4, pattern length in bits (2..16)
PAT_RST, 4'b1101, pattern value loaded at reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  scheduler run enable
cfg_load  in  1  single-cycle pulse: load cfg_pattern, clear all contexts
cfg_pattern  in  PAT_W  new pattern, MSB = oldest bit
req_valid  in  NCH  per-channel bit valid
req_bit  in  NCH  per-channel serial data bit
req_ready  out  NCH  one-hot grant; combinational from req_valid/state
hit  out  1  registered one-cycle match pulse
hit_ch  out  CH_W  channel that matched; valid while hit=1
busy  out  1  high while contexts are being cleared

Behaviour:
- Reset values: state=S_CLEAR, clr_idx=0, rr_ptr=0, pattern=PAT_RST, hit=0, hit_ch=0, busy=1, req_ready=0. Histories and fill counters are undefined until cleared.
- FSM states: S_CLEAR and S_RUN.
- S_CLEAR:
  - Each cycle zeroes hist[clr_idx] and fill[clr_idx], then increments clr_idx.
  - After clearing index NCH-1, go to S_RUN and reset clr_idx to 0. Duration is exactly NCH cycles.
  - busy=1 and req_ready=0 throughout.
- S_RUN: busy=0.
  - When enable=1 and cfg_load=0, grant g = first channel with req_valid set, searching from rr_ptr upward with wrap-around.
  - req_ready[g]=1; all other ready bits are 0. If no channel is valid, no grant and rr_ptr holds.
  - A transfer is valid && ready on g. On transfer:
    - hist[g] <= {hist[g][PAT_W-2:0], req_bit[g]}
    - fill[g] saturates at PAT_W-1
    - rr_ptr <= (g+1) mod NCH
- Match on transfer: the new history equals pattern AND fill[g] == PAT_W-1 before the update. This fill guard means no hit occurs before PAT_W bits have been received since the last clear.
- Detection is overlapping: history is never flushed on a match.
- hit=1 and hit_ch=g on the clock edge after the transfer (latency 1). Otherwise hit=0 and hit_ch holds its last value. Back-to-back hits in consecutive cycles are legal, on the same or different channels.
- enable=0 in S_RUN: req_ready=0; histories, fill and rr_ptr hold; hit drops to 0 the next cycle.
- cfg_load=1 in any state:
  - req_ready=0 that cycle, so any offered bit is not consumed.
  - pattern <= cfg_pattern; state <= S_CLEAR; clr_idx <= 0.
  - A pending hit from the previous cycle's transfer still pulses normally.
  - cfg_load during S_CLEAR restarts the clear from index 0.
- Asynchronous reset mid-operation immediately forces all reset values. No partial hit is emitted afterwards.
- enable is ignored in S_CLEAR; clearing always completes.

Optional Feature:
Macro: SEQ_DET_SCHED_HITCNT_EN.
- Defined: adds output port hit_cnt [15:0].
  - Increments by 1 on every cycle hit=1, saturating at 16'hFFFF.
  - Resets to 0 on reset and on cfg_load.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
1. Release reset with all req_valid=1 -> busy=1 and req_ready=0 for exactly 4 cycles; first grant is ch0 on cycle 5.
2. Pattern 1101, ch0 alone sends 1,1,0,1,1,0,1 -> hit=1 with hit_ch=0 one cycle after the 4th transfer and again after the 7th (overlap). No other hits.
3. All 4 channels valid every cycle -> grants 0,1,2,3,0,...; ch2 stream 1,1,0,1, others 0 -> single hit, hit_ch=2, one cycle after ch2's 4th grant.
4. cfg_pattern=0000 plus cfg_load, then ch3 sends five 0s -> no hit on transfers 1-3; hits after transfers 4 and 5.
5. ch1 has history 110, then cfg_load with pattern 0110 while ch1 is valid -> ready=0 on the load cycle and for 4 clear cycles. The next bit 1 on ch1 gives no hit; hit_cnt (if enabled) reads 0.
6. enable=0 for 10 cycles mid-pattern, then the remaining bits are sent -> no grants while disabled; the pattern completes and hit fires with the correct hit_ch. With the macro defined, hit_cnt increments by exactly 1.

Source files
------------

// File: rtl/seq_det_sched.sv
// Time-shared overlapping serial pattern detector: NCH bit-serial channels share one compare engine via round-robin.
// Latency: hit/hit_ch are registered one cycle after the granting transfer; req_ready is combinational.
// Backpressure: one channel is granted per cycle; no grants while clearing, while disabled, or on a cfg_load cycle.
// Optional macro SEQ_DET_SCHED_HITCNT_EN adds a saturating 16-bit hit_cnt output.
module seq_det_sched #(
   parameter int               NCH     = 4,
   parameter int               CH_W    = 2,
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PAT_RST = 4'b1101
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [NCH-1:0]   req_valid,
   input  logic [NCH-1:0]   req_bit,
   output logic [NCH-1:0]   req_ready,
   output logic             hit,
   output logic [CH_W-1:0]  hit_ch,
   output logic             busy
`ifdef SEQ_DET_SCHED_HITCNT_EN
   ,
   output logic [15:0]      hit_cnt
`endif
);

   // Fill counter only needs to reach PAT_W-1, where it saturates.
   localparam int              FW       = $clog2(PAT_W);
   localparam logic [FW-1:0]   FILL_MAX = FW'(PAT_W - 1);
   localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NCH - 1);

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CH_W-1:0]   clr_idx;
   logic [CH_W-1:0]   clr_idx_nxt;
   logic [CH_W-1:0]   rr_ptr;
   logic [PAT_W-1:0]  pattern;

   // Per-channel context: shift history and bits-seen counter.
   logic [PAT_W-1:0]  hist [NCH];
   logic [FW-1:0]     fill [NCH];

   logic              gnt_vld;
   logic [CH_W-1:0]   gnt_idx;
   logic [PAT_W-1:0]  hist_new;
   logic              match;

   // Round-robin search for the first valid channel starting at rr_ptr.
   always_comb begin
      int j;
      j       = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      if (state == S_RUN && enable && !cfg_load) begin
         for (int i = 0; i < NCH; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NCH) j = j - NCH;
            if (!gnt_vld && req_valid[j]) begin
               gnt_vld = 1'b1;
               gnt_idx = CH_W'(j);
            end
         end
      end
   end

   // One-hot ready; a grant is only ever given to a valid channel, so grant == transfer.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         req_ready[i] = gnt_vld && (gnt_idx == CH_W'(i));
      end
   end

   // Compare engine: shifted history of the granted channel against the pattern, gated by fill.
   always_comb begin
      hist_new = {hist[gnt_idx][PAT_W-2:0], req_bit[gnt_idx]};
      match    = gnt_vld && (hist_new == pattern) && (fill[gnt_idx] == FILL_MAX);
   end

   // Next-state logic: cfg_load always restarts clearing from index 0.
   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      busy        = (state == S_CLEAR);
      if (cfg_load) begin
         state_nxt   = S_CLEAR;
         clr_idx_nxt = '0;
      end else if (state == S_CLEAR) begin
         if (clr_idx == LAST_CH) begin
            state_nxt   = S_RUN;
            clr_idx_nxt = '0;
         end else begin
            clr_idx_nxt = clr_idx + CH_W'(1);
         end
      end
   end

   // Control registers: FSM, clear index, scheduler pointer, pattern and hit outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_CLEAR;
         clr_idx <= '0;
         rr_ptr  <= '0;
         pattern <= PAT_RST;
         hit     <= 1'b0;
         hit_ch  <= '0;
      end else begin
         state   <= state_nxt;
         clr_idx <= clr_idx_nxt;
         hit     <= match;
         if (match) hit_ch <= gnt_idx;
         if (gnt_vld) rr_ptr <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + CH_W'(1);
         if (cfg_load) pattern <= cfg_pattern;
      end
   end

   // Channel contexts carry no reset; they are scrubbed one per cycle while clearing.
   always_ff @(posedge clk) begin
      if (state == S_CLEAR) begin
         hist[clr_idx] <= '0;
         fill[clr_idx] <= '0;
      end else if (gnt_vld) begin
         hist[gnt_idx] <= hist_new;
         if (fill[gnt_idx] != FILL_MAX) fill[gnt_idx] <= fill[gnt_idx] + FW'(1);
      end
   end

`ifdef SEQ_DET_SCHED_HITCNT_EN
   // Saturating count of hit pulses, cleared with a new pattern.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_cnt <= '0;
      end else if (cfg_load) begin
         hit_cnt <= '0;
      end else if (hit && hit_cnt != 16'hFFFF) begin
         hit_cnt <= hit_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Self-checking bench for seq_det_sched: directed scenarios followed by randomized traffic.
// A behavioural model (bits-since-clear counts, integer histories, clear countdown) predicts every output.
// Define SEQ_DET_SCHED_HITCNT_EN to also check hit_cnt.
module tb_seq_det_sched;

   localparam int NCH   = 4;
   localparam int CH_W  = 2;
   localparam int PAT_W = 4;
   localparam int PMASK = (1 << PAT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic             cfg_load;
   logic [PAT_W-1:0] cfg_pattern;
   logic [NCH-1:0]   req_valid;
   logic [NCH-1:0]   req_bit;
   logic [NCH-1:0]   req_ready;
   logic             hit;
   logic [CH_W-1:0]  hit_ch;
   logic             busy;
`ifdef SEQ_DET_SCHED_HITCNT_EN
   logic [15:0]      hit_cnt;
`endif

   always #5 clk = ~clk;

   seq_det_sched #(.NCH(NCH), .CH_W(CH_W), .PAT_W(PAT_W), .PAT_RST(4'b1101)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .req_valid   (req_valid),
      .req_bit     (req_bit),
      .req_ready   (req_ready),
      .hit         (hit),
      .hit_ch      (hit_ch),
      .busy        (busy)
`ifdef SEQ_DET_SCHED_HITCNT_EN
      ,
      .hit_cnt     (hit_cnt)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   int dut_hits = 0;

   // Model state
   int m_clr_left;
   int m_rr;
   int m_pat;
   int m_hit;
   int m_hit_ch;
   int m_hitcnt;
   int m_hist [NCH];
   int m_cnt  [NCH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_clear_ctx();
      for (int c = 0; c < NCH; c++) begin
         m_hist[c] = 0;
         m_cnt[c]  = 0;
      end
   endfunction

   function automatic void model_reset();
      m_clr_left = NCH;
      m_rr       = 0;
      m_pat      = 4'b1101;
      m_hit      = 0;
      m_hit_ch   = 0;
      m_hitcnt   = 0;
      model_clear_ctx();
   endfunction

   function automatic int exp_grant();
      int c;
      if (m_clr_left != 0 || !enable || cfg_load) return -1;
      for (int k = 0; k < NCH; k++) begin
         c = (m_rr + k) % NCH;
         if (req_valid[c]) return c;
      end
      return -1;
   endfunction

   task automatic drive(input logic en, input logic cfg, input logic [PAT_W-1:0] cp,
                        input logic [NCH-1:0] vld, input logic [NCH-1:0] bits);
      enable      = en;
      cfg_load    = cfg;
      cfg_pattern = cp;
      req_valid   = vld;
      req_bit     = bits;
   endtask

   // One clock: check outputs at negedge, advance the model at posedge, return at posedge+1.
   task automatic cycle();
      int   g;
      int   nh;
      @(negedge clk);
      g = exp_grant();
      check("ready",  req_ready, (g < 0) ? 0 : (1 << g));
      check("busy",   busy,      (m_clr_left > 0) ? 1 : 0);
      check("hit",    hit,       m_hit);
      check("hit_ch", hit_ch,    m_hit_ch);
`ifdef SEQ_DET_SCHED_HITCNT_EN
      check("hit_cnt", hit_cnt,  m_hitcnt);
`endif
      if (hit) dut_hits++;
      @(posedge clk);
      nh = 0;
      if (cfg_load) m_hitcnt = 0;
      else if (m_hit != 0 && m_hitcnt < 65535) m_hitcnt++;
      if (g >= 0) begin
         m_hist[g] = ((m_hist[g] << 1) | int'(req_bit[g])) & PMASK;
         m_cnt[g]++;
         if (m_cnt[g] >= PAT_W && m_hist[g] == m_pat) begin
            nh       = 1;
            m_hit_ch = g;
         end
         m_rr = (g + 1) % NCH;
      end
      if (cfg_load) begin
         m_pat      = int'(cfg_pattern);
         m_clr_left = NCH;
         model_clear_ctx();
      end else if (m_clr_left > 0) begin
         m_clr_left--;
      end
      m_hit = nh;
      #1;
   endtask

   task automatic load_and_clear(input logic [PAT_W-1:0] p);
      drive(1'b1, 1'b1, p, '0, '0);
      cycle();
      drive(1'b1, 1'b0, '0, '0, '0);
      repeat (NCH) cycle();
   endtask

   task automatic idle(input int n);
      drive(1'b1, 1'b0, '0, '0, '0);
      repeat (n) cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] s2;
      logic [3:0] s3;
      int         base;
      s2 = 7'b1101101;
      s3 = 4'b1101;
      base = 0;

      reset = 1'b1;
      drive(1'b0, 1'b0, '0, '0, '0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_hit",    hit,       0);
      check("rst_hit_ch", hit_ch,    0);
      check("rst_busy",   busy,      1);
      check("rst_ready",  req_ready, 0);
      reset = 1'b0;

      // 1: all channels valid out of reset -> 4 clear cycles, then ch0 first
      drive(1'b1, 1'b0, '0, '1, '0);
      repeat (NCH) cycle();
      check("first_grant", req_ready, 4'b0001);
      cycle();
      load_and_clear(4'b1101);

      // 2: ch0 alone, overlapping 1101101 -> two hits
      dut_hits = 0;
      for (int i = 6; i >= 0; i--) begin
         drive(1'b1, 1'b0, '0, 4'b0001, {3'b000, s2[i]});
         cycle();
      end
      idle(2);
      check("s2_hits", dut_hits, 2);

      // 3: all valid, ch2 streams 1101 one bit per round
      dut_hits = 0;
      for (int r = 3; r >= 0; r--) begin
         drive(1'b1, 1'b0, '0, 4'b1111, {1'b0, s3[r], 2'b00});
         repeat (NCH) cycle();
      end
      idle(2);
      check("s3_hits", dut_hits, 1);

      // 4: pattern 0000, ch3 sends five zeros -> hits after 4th and 5th
      load_and_clear(4'b0000);
      dut_hits = 0;
      drive(1'b1, 1'b0, '0, 4'b1000, 4'b0000);
      repeat (5) cycle();
      idle(2);
      check("s4_hits", dut_hits, 2);

      // 5: ch1 holds 110, reload 0110 while ch1 valid; next 1 must not hit
      load_and_clear(4'b1101);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, '0, 4'b0010, (i < 2) ? 4'b0010 : 4'b0000);
         cycle();
      end
      dut_hits = 0;
      drive(1'b1, 1'b1, 4'b0110, 4'b0010, 4'b0010);
      cycle();
      drive(1'b1, 1'b0, '0, 4'b0010, 4'b0010);
      repeat (NCH + 1) cycle();
      idle(2);
      check("s5_hits", dut_hits, 0);
`ifdef SEQ_DET_SCHED_HITCNT_EN
      check("s5_hit_cnt", hit_cnt, 0);
      base = int'(hit_cnt);
`endif

      // 6: ch2 sends 01, 10 disabled cycles, then 10 -> one hit on ch2
      dut_hits = 0;
      drive(1'b1, 1'b0, '0, 4'b0100, 4'b0000); cycle();
      drive(1'b1, 1'b0, '0, 4'b0100, 4'b0100); cycle();
      drive(1'b0, 1'b0, '0, 4'b1111, 4'b1111);
      repeat (10) cycle();
      drive(1'b1, 1'b0, '0, 4'b0100, 4'b0100); cycle();
      drive(1'b1, 1'b0, '0, 4'b0100, 4'b0000); cycle();
      idle(2);
      check("s6_hits", dut_hits, 1);
`ifdef SEQ_DET_SCHED_HITCNT_EN
      check("s6_hit_cnt", hit_cnt, base + 1);
`endif

      // Randomized traffic with occasional reloads and one asynchronous reset
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom % 10) != 0, ($urandom % 150) == 0,
               PAT_W'($urandom), NCH'($urandom), NCH'($urandom));
         cycle();
         if (n == 1500) begin
            #2;
            reset = 1'b1;
            #1;
            check("arst_hit",   hit,       0);
            check("arst_busy",  busy,      1);
            check("arst_ready", req_ready, 0);
            check("arst_ch",    hit_ch,    0);
            model_reset();
            @(posedge clk);
            #1;
            reset = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
